// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - shared types and widths for the bit serializer
package serializer_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} ser_state_t;

    localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-in/serial-out word serializer with optional inter-word gap
module bit_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             bit_o,
    output logic             bit_valid_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] LAST_GAP = GAP_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    ser_state_t           state;
    logic [WIDTH-1:0]     shreg;
    logic [CNT_W-1:0]     bit_cnt;
    logic [GAP_CNT_W-1:0] gap_cnt;
    logic                 last_bit;
    logic                 accept;

    // bit_cnt is the index of the bit currently on bit_o, so the last-bit
    // cycle is known combinationally and a gapless reload can be offered there.
    assign last_bit = (state == SHIFT) && (bit_cnt == LAST_BIT);
    assign ready_o  = (state == IDLE) || (last_bit && (GAP_CYCLES == 0));
    assign accept   = valid_i && ready_o;

    function automatic logic head(input logic [WIDTH-1:0] d);
        return MSB_FIRST ? d[WIDTH-1] : d[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] d);
        return MSB_FIRST ? (d << 1) : (d >> 1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            bit_o       <= 1'b0;
            bit_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else if (accept) begin
            // First bit goes straight to the output register; the rest wait in shreg.
            state       <= SHIFT;
            shreg       <= advance(data_i);
            bit_cnt     <= '0;
            bit_o       <= head(data_i);
            bit_valid_o <= 1'b1;
            busy_o      <= 1'b1;
            done_o      <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    if (last_bit) begin
                        bit_o       <= 1'b0;
                        bit_valid_o <= 1'b0;
                        done_o      <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            state   <= GAP;
                            gap_cnt <= '0;
                            busy_o  <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end else begin
                        bit_o       <= head(shreg);
                        shreg       <= advance(shreg);
                        bit_cnt     <= bit_cnt + 1'b1;
                        bit_valid_o <= 1'b1;
                        busy_o      <= 1'b1;
                        done_o      <= (bit_cnt == LAST_BIT - 1'b1);
                    end
                end
                GAP: begin
                    bit_o       <= 1'b0;
                    bit_valid_o <= 1'b0;
                    done_o      <= 1'b0;
                    if (gap_cnt == LAST_GAP) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                        busy_o  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    bit_o       <= 1'b0;
                    bit_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                    done_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule
